// File: rtl/seg_pkg.sv
// Shared definitions for the dynamic 7-segment scanner: digit codes,
// converter states, segment decode and output polarity.
package seg_pkg;

  localparam logic [3:0] BLANK = 4'd10;
  localparam logic [3:0] DASH  = 4'd11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_e;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      DASH:    return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] polarity(input logic [7:0] v, input bit act_low);
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_dynamic_scan_if.sv
// Value/attribute inputs and display outputs of the dynamic scanner.
interface seg_dynamic_scan_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic              sign;
  logic              seg_en;
  logic [DIGITS-1:0] blink;
  logic [2:0]        bright;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;
  logic              overflow;

  modport master (output data, point, sign, seg_en, blink, bright,
                  input  sel, seg, overflow);
  modport slave  (input  data, point, sign, seg_en, blink, bright,
                  output sel, seg, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; done pulses DATA_W+2 cycles after start.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int NW = $clog2(DATA_W + 1);

  b2b_state_e          state;
  logic [DATA_W-1:0]   sr;
  logic [NW-1:0]       left;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      sr    <= '0;
      left  <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          sr    <= bin;
          bcd   <= '0;
          ovf   <= 1'b0;
          left  <= NW'(DATA_W);
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          // A set bit leaving the top digit means the value needs more than DIGITS digits
          bcd  <= {adj[4*DIGITS-2:0], sr[DATA_W-1]};
          ovf  <= ovf | adj[4*DIGITS-1];
          sr   <= sr << 1;
          left <= left - NW'(1);
          if (left == NW'(1)) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/seg_dynamic_scan.sv
// Multi-digit dynamic 7-segment driver with blanking, sign, dp, blink and PWM dimming.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int DATA_W      = 20,
  parameter int CNT_MAX     = 49_999,
  parameter int BLINK_TICKS = 250,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  seg_dynamic_scan_if.slave bus
);
  localparam int CW   = $clog2(CNT_MAX + 1);
  localparam int IW   = $clog2(DIGITS);
  localparam int BW   = $clog2(BLINK_TICKS + 1);
  localparam int STEP = (CNT_MAX + 1) >> 3;

  if (CNT_MAX < DATA_W + 2) begin : g_chk_cnt
    $error("CNT_MAX must be >= DATA_W+2");
  end
  if (DIGITS < 2 || DIGITS > 8) begin : g_chk_digits
    $error("DIGITS must be in 2..8");
  end

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     bcnt;
  logic              phase, tick, frame_start;
  logic              sign_l;
  logic [DIGITS-1:0] point_l;

  assign tick        = cnt == CW'(CNT_MAX);
  assign frame_start = tick && idx == IW'(DIGITS - 1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      sign_l  <= 1'b0;
      point_l <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        if (bcnt == BW'(BLINK_TICKS - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
      if (frame_start) begin
        sign_l  <= bus.sign;
        point_l <= bus.point;
      end
    end
  end

  logic                busy, done, bcd_ovf;
  logic [4*DIGITS-1:0] bcd;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_b2b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (frame_start && !busy),
    .bin      (bus.data),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .ovf      (bcd_ovf)
  );

  logic [3:0]  code_n    [DIGITS];
  logic [3:0]  disp_code [DIGITS];
  logic [DIGITS-1:0] disp_pt;
  logic        ovf_n, ovf_q;
  int unsigned msd;

  always_comb begin
    msd = 0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0 || point_l[i]) msd = i;
    ovf_n = bcd_ovf || (sign_l && msd == DIGITS - 1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i <= msd)                   code_n[i] = bcd[4*i +: 4];
      else if (sign_l && i == msd + 1) code_n[i] = DASH;
      else                            code_n[i] = BLANK;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_code <= '{default: BLANK};
      disp_pt   <= '0;
      ovf_q     <= 1'b0;
    end else if (done) begin
      disp_code <= code_n;
      disp_pt   <= point_l;
      ovf_q     <= ovf_n;
    end
  end

  logic [CW:0]       thr;
  logic              lit, dark;
  logic [3:0]        cur;
  logic [DIGITS-1:0] sel_n, sel_q;
  logic [7:0]        seg_n, seg_q;

  always_comb begin
    thr   = (CW+1)'(STEP) * ((CW+1)'(bus.bright) + (CW+1)'(1));
    lit   = bus.seg_en && ({1'b0, cnt} < thr);
    cur   = ovf_q ? DASH : disp_code[idx];
    dark  = phase && bus.blink[idx];
    sel_n = '0;
    seg_n = '0;
    if (lit) begin
      sel_n[idx] = 1'b1;
      seg_n      = {disp_pt[idx] & ~dark, dark ? 7'h00 : ~seg_pattern(cur)};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q <= SEL_ACT_LOW ? '1 : '0;
      seg_q <= SEG_ACT_LOW ? '1 : '0;
    end else begin
      sel_q <= sel_n ^ {DIGITS{SEL_ACT_LOW}};
      seg_q <= polarity(seg_n, SEG_ACT_LOW);
    end
  end

  assign bus.sel      = sel_q;
  assign bus.seg      = seg_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Bench for seg_dynamic_scan: time-based display model plus directed literal checks.
module tb_seg_dynamic_scan;
  localparam int DIGITS = 6, DATA_W = 20, CNT_MAX = 63, BLINK_TICKS = 4;
  localparam int SLOT = CNT_MAX + 1, FRAME = SLOT * DIGITS;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  seg_dynamic_scan_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg_dynamic_scan #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .CNT_MAX(CNT_MAX), .BLINK_TICKS(BLINK_TICKS),
    .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  int checks = 0, errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Active-high {g..a} for codes 0-9, blank, dash
  logic [6:0] seg_tab [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00, 7'h40};

  int unsigned n;
  int unsigned m_code [DIGITS];
  logic [DIGITS-1:0] m_pt;
  logic m_ovf;
  bit pend;
  int unsigned pend_due, pend_val;
  logic pend_sign;
  logic [DIGITS-1:0] pend_pt;
  logic [DIGITS-1:0] exp_sel;
  logic [7:0] exp_seg;
  logic exp_ovf;

  task automatic model_clear();
    n = 0;
    foreach (m_code[i]) m_code[i] = 10;
    m_pt = '0; m_ovf = 1'b0; pend = 0;
    exp_sel = '0; exp_seg = 8'hFF; exp_ovf = 1'b0;
  endtask

  task automatic load_display(input int unsigned v, input logic s, input logic [DIGITS-1:0] pt);
    int unsigned d [DIGITS];
    int unsigned msd = 0, p = 1;
    for (int i = 0; i < DIGITS; i++) begin d[i] = (v / p) % 10; p = p * 10; end
    for (int i = 0; i < DIGITS; i++) if (d[i] != 0 || pt[i]) msd = i;
    m_ovf = (v > p - 1) || (s && msd == DIGITS - 1);
    for (int i = 0; i < DIGITS; i++)
      m_code[i] = (i <= msd) ? d[i] : ((s && i == msd + 1) ? 11 : 10);
    m_pt = pt;
  endtask

  task automatic model_step();
    int unsigned cnt, slot, idx, code;
    bit phase, dark;
    cnt   = n % SLOT;
    slot  = n / SLOT;
    idx   = slot % DIGITS;
    phase = ((slot / BLINK_TICKS) % 2) == 1;
    if (bus.seg_en && cnt < (SLOT / 8) * (int'(bus.bright) + 1)) begin
      code    = m_ovf ? 11 : m_code[idx];
      dark    = phase && bus.blink[idx];
      exp_sel = DIGITS'(1 << idx);
      exp_seg = ~{m_pt[idx] && !dark, dark ? 7'h00 : seg_tab[code]};
    end else begin
      exp_sel = '0;
      exp_seg = 8'hFF;
    end
    if (pend && n == pend_due) begin
      load_display(pend_val, pend_sign, pend_pt);
      pend = 0;
    end
    exp_ovf = m_ovf;
    if (cnt == SLOT - 1 && idx == DIGITS - 1) begin
      pend = 1; pend_val = bus.data; pend_sign = bus.sign; pend_pt = bus.point;
      pend_due = n + DATA_W + 2;
    end
    n++;
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      model_clear();
      cmp("model_rst_sel", 32'(bus.sel), 32'(exp_sel));
      cmp("model_rst_seg", 32'(bus.seg), 32'(exp_seg));
      cmp("model_rst_ovf", 32'(bus.overflow), 32'(exp_ovf));
    end else begin
      cmp("model_sel", 32'(bus.sel), 32'(exp_sel));
      cmp("model_seg", 32'(bus.seg), 32'(exp_seg));
      cmp("model_ovf", 32'(bus.overflow), 32'(exp_ovf));
      model_step();
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_digit(input string name, input int k, input logic [7:0] exp);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge sys_clk); #1;
      if (bus.sel === DIGITS'(1 << k)) found = 1;
    end
    if (found) cmp(name, 32'(bus.seg), 32'(exp));
    else begin
      checks++; errors++;
      $display("FAIL %s: sel never became %0h (got %0h)", name, 1 << k, bus.sel);
    end
  endtask

  task automatic count_active(input string name, input int exp);
    int c = 0;
    repeat (FRAME) begin
      @(posedge sys_clk); #1;
      if (bus.sel != '0) c++;
    end
    cmp(name, 32'(c), 32'(exp));
  endtask

  task automatic wait_frame_pos(input int pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge sys_clk); #1;
      if (n % FRAME == pos) return;
    end
    checks++; errors++;
    $display("FAIL frame_pos: position %0d not reached (n=%0d)", pos, n);
  endtask

  initial begin
    int run;
    bus.data = '0; bus.point = '0; bus.sign = 1'b0; bus.seg_en = 1'b1;
    bus.blink = '0; bus.bright = 3'd7;
    cyc(3);
    cmp("reset_sel", 32'(bus.sel), 32'h0);
    cmp("reset_seg", 32'(bus.seg), 32'hFF);
    cmp("reset_ovf", 32'(bus.overflow), 32'h0);
    sys_rst_n = 1'b1;

    bus.data = 20'd1234;
    cyc(2 * FRAME);
    expect_digit("d1234_0", 0, 8'h99);
    expect_digit("d1234_1", 1, 8'hB0);
    run = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clk); #1;
      if (bus.sel === 6'b000010) run++; else break;
    end
    cmp("slot_len", 32'(run), 32'd64);
    expect_digit("d1234_2", 2, 8'hA4);
    expect_digit("d1234_3", 3, 8'hF9);
    expect_digit("d1234_4", 4, 8'hFF);
    expect_digit("d1234_5", 5, 8'hFF);
    cmp("d1234_ovf", 32'(bus.overflow), 32'h0);

    bus.data = 20'd56; bus.sign = 1'b1; bus.point = 6'b000100;
    cyc(2 * FRAME);
    expect_digit("d56_0", 0, 8'h82);
    expect_digit("d56_2_dp", 2, 8'h40);
    expect_digit("d56_3_minus", 3, 8'hBF);
    expect_digit("d56_4", 4, 8'hFF);
    cmp("d56_ovf", 32'(bus.overflow), 32'h0);

    bus.data = 20'd1_000_000; bus.sign = 1'b0; bus.point = '0;
    cyc(2 * FRAME);
    cmp("big_ovf", 32'(bus.overflow), 32'h1);
    expect_digit("big_0_dash", 0, 8'hBF);
    expect_digit("big_5_dash", 5, 8'hBF);
    bus.data = 20'd999_999; bus.sign = 1'b1;
    cyc(2 * FRAME);
    cmp("max_neg_ovf", 32'(bus.overflow), 32'h1);
    bus.sign = 1'b0;
    cyc(2 * FRAME);
    cmp("max_pos_ovf", 32'(bus.overflow), 32'h0);
    expect_digit("max_0", 0, 8'h90);
    expect_digit("max_5", 5, 8'h90);

    bus.bright = 3'd1;
    cyc(2);
    count_active("bright1_duty", 96);
    bus.bright = 3'd7;
    cyc(2);
    count_active("bright7_duty", FRAME);

    bus.blink = 6'b000001;
    cyc(3 * FRAME);
    bus.blink = '0;

    bus.data = 20'd42;
    cyc(2 * FRAME);
    wait_frame_pos(5);
    bus.data = 20'd77;
    expect_digit("latched_frame", 1, 8'h99);

    cyc(FRAME);
    cmp("en_before", 32'(bus.sel != '0), 32'h1);
    bus.seg_en = 1'b0;
    cyc(1);
    cmp("en_off_sel", 32'(bus.sel), 32'h0);
    cmp("en_off_seg", 32'(bus.seg), 32'hFF);
    cyc(9);
    bus.seg_en = 1'b1;
    cyc(FRAME);

    wait_frame_pos(5);
    sys_rst_n = 1'b0;
    #1;
    cmp("midrst_sel", 32'(bus.sel), 32'h0);
    cmp("midrst_seg", 32'(bus.seg), 32'hFF);
    cmp("midrst_ovf", 32'(bus.overflow), 32'h0);
    cyc(3);
    sys_rst_n = 1'b1;
    expect_digit("post_rst_blank", 2, 8'hFF);
    cyc(2 * FRAME);
    expect_digit("post_rst_77", 0, 8'hF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
